// File: rtl/mux4_scan_ctrl_if.sv
// mux4_scan_ctrl_if: scan request, mux select/sense and frame handshake bundle.
interface mux4_scan_ctrl_if;
   logic       start;
   logic       mux_out;
   logic       s0;
   logic       s1;
   logic [3:0] frame;
   logic       frame_valid;
   logic       frame_ready;
   logic       busy;
   modport master (output start, mux_out, frame_ready, input s0, s1, frame, frame_valid, busy);
   modport slave  (input start, mux_out, frame_ready, output s0, s1, frame, frame_valid, busy);
endinterface

// File: rtl/mux4_scan_ctrl.sv
// mux4_scan_ctrl: steps a 4:1 mux through all select codes, samples its output
// after DWELL cycles per code and presents the 4-bit frame with a valid/ready handshake.
module mux4_scan_ctrl #(
   parameter int DWELL = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   mux4_scan_ctrl_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;
   localparam logic [3:0] LAST = 4'(DWELL - 1);
   state_t     state_q, state_d;
   logic [1:0] sel_q, sel_d;
   logic [3:0] cnt_q, cnt_d;
   logic [3:0] shadow_q, shadow_d;
   logic [3:0] frame_q, frame_d;
   logic       fv_q, fv_d;
   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      cnt_d    = cnt_q;
      shadow_d = shadow_q;
      frame_d  = frame_q;
      fv_d     = fv_q;
      case (state_q)
         IDLE: if (bus.start) begin
            state_d = SCAN;
            sel_d   = 2'd0;
            cnt_d   = 4'd0;
         end
         SCAN: if (cnt_q == LAST) begin
            cnt_d            = 4'd0;
            shadow_d[sel_q]  = bus.mux_out;
            sel_d            = sel_q + 2'd1;
            // last code: publish the frame without wrapping to a fifth sample
            if (sel_q == 2'd3) begin
               frame_d = {bus.mux_out, shadow_q[2:0]};
               fv_d    = 1'b1;
               state_d = HOLD;
               sel_d   = 2'd0;
            end
         end else begin
            cnt_d = cnt_q + 4'd1;
         end
         HOLD: if (bus.frame_ready) begin
            fv_d    = 1'b0;
            state_d = bus.start ? SCAN : IDLE;
            sel_d   = 2'd0;
            cnt_d   = 4'd0;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         sel_q    <= 2'd0;
         cnt_q    <= 4'd0;
         shadow_q <= 4'd0;
         frame_q  <= 4'd0;
         fv_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
         frame_q  <= frame_d;
         fv_q     <= fv_d;
      end
   end
   assign bus.s0          = sel_q[0];
   assign bus.s1          = sel_q[1];
   assign bus.frame       = frame_q;
   assign bus.frame_valid = fv_q;
   assign bus.busy        = state_q != IDLE;
endmodule

// File: doc/mux4_scan_ctrl.md
MUX4_SCAN_CTRL -- requirements
Module: mux4_scan_ctrl

Interface
REQ-001 Parameter DWELL, default 2: clock cycles each select code is held before the mux output is sampled; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  scan request, sampled on rising clk edge.
REQ-005 mux_out  input  1  output of the downstream 4:1 mux (out port of mux4_1).
REQ-006 s0  output  1  mux select LSB; drives mux4_1 s0.
REQ-007 s1  output  1  mux select MSB; drives mux4_1 s1.
REQ-008 frame  output  4  captured frame; frame[i] = mux_out sampled while {s1,s0} = i.
REQ-009 frame_valid  output  1  frame holds a completed scan.
REQ-010 frame_ready  input  1  consumer accepts frame.
REQ-011 busy  output  1  high whenever state is not IDLE.

Function
REQ-012 The block SHALL implement the FSM states IDLE, SCAN and HOLD, encoded in a registered state variable.
REQ-013 In IDLE: {s1,s0}=00, frame_valid=0; start=1 at an edge -> SCAN with sel=0, dwell counter=0.
REQ-014 In SCAN: {s1,s0} SHALL be driven from a registered 2-bit sel and held stable for exactly DWELL cycles per code.
REQ-015 The dwell counter SHALL increment each SCAN cycle; at the edge where counter==DWELL-1, mux_out SHALL be written to shadow bit [sel], counter cleared, sel incremented.
REQ-016 When the sample at sel=3 is taken: frame <= shadow with bit 3 = mux_out, frame_valid <= 1, state -> HOLD, sel -> 0 (no wrap to a fifth sample).
REQ-017 Latency: start accepted at edge k -> frame_valid high after edge k+4*DWELL.
REQ-018 In HOLD: frame and frame_valid SHALL stay constant until an edge with frame_ready=1; {s1,s0}=00.
REQ-019 HOLD, frame_ready=1, start=0 at the same edge -> IDLE, frame_valid=0.
REQ-020 HOLD, frame_ready=1 and start=1 at the same edge -> SCAN directly (sel=0, counter=0), frame_valid=0, busy stays 1.
REQ-021 start SHALL be ignored in SCAN, and in HOLD unless frame_ready=1 at the same edge; no request queuing.
REQ-022 frame_ready SHALL be ignored outside HOLD.
REQ-023 frame SHALL retain the last completed value after handshake until the next scan completes; partial scans SHALL never update frame.
REQ-024 busy SHALL be combinational from state (state != IDLE).

Reset
REQ-025 rst_n=0 SHALL immediately, without a clock, force state=IDLE, sel=00, counter=0, shadow=0, frame=0000, frame_valid=0, busy=0, s0=s1=0.
REQ-026 Reset asserted mid-SCAN or in HOLD SHALL abort the scan and discard the frame; after release the block waits in IDLE for a new start.
REQ-027 The first edge after rst_n deassertion SHALL be an ordinary IDLE cycle (start sampled normally).

Verification
REQ-028 DWELL=2, mux model a=1,b=0,c=1,d=1, start pulse at edge k -> {s1,s0} = 00,01,10,11 for 2 cycles each; frame_valid=1 after edge k+8; frame=4'b1101.
REQ-029 Backpressure: frame_ready=0 for 5 cycles in HOLD with start pulses and changing mux inputs -> frame_valid stays 1, frame unchanged, no new scan; frame_ready=1 -> IDLE next edge.
REQ-030 Same-edge frame_ready=1 and start=1 in HOLD -> SCAN next cycle, {s1,s0}=00, busy never drops, second frame correct.
REQ-031 rst_n pulled low while {s1,s0}=10 -> all outputs 0 before next clock edge; after release, frame_valid stays 0 for 20 cycles without start.
REQ-032 start held high throughout SCAN -> select sequence unchanged, exactly one frame per accepted start.
REQ-033 DWELL=1, start held high, frame_ready tied 1 -> back-to-back frames with one HOLD cycle between scans, each select code held 1 cycle.
